hash_core_arbiter: RTL and testbench

//  Shares one H_for_s_tree hash core among NREQ requesters: seed-tree expansion, commitment

---
 rtl/hash_core_arbiter.sv | 178 +++++++++++++++++
 tb/tb_hash_core_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_core_arbiter.sv
// Round-robin arbiter that shares one hash core among NREQ requesters and returns each digest
// with a one-cycle done pulse. Optional watchdog enabled by defining HARB_TIMEOUT_EN.
module hash_core_arbiter #(
    parameter int NREQ   = 4,
    parameter int MSG_W  = 512,
    parameter int DIG_W  = 256,
    parameter int TO_CYC = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*MSG_W-1:0]   msg_in,
    output logic [NREQ-1:0]         done,
    output logic [DIG_W-1:0]        digest,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic [MSG_W-1:0]        core_msg,
    output logic                    core_start,
    input  logic [DIG_W-1:0]        core_digest,
    input  logic                    core_done,
    output logic                    err
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_DRAIN
    } state_t;

    if (NREQ < 2 || NREQ > 8 || TO_CYC < 1) begin : g_bad_cfg
        $error("hash_core_arbiter: NREQ must be 2..8 and TO_CYC >= 1");
    end

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [MSG_W-1:0] core_msg_q, core_msg_d;
    logic             core_start_q, core_start_d;
    logic [DIG_W-1:0] digest_q, digest_d;
    logic [NREQ-1:0]  done_q, done_d;

    logic [MSG_W-1:0] msg_arr [NREQ];
    logic [IDW-1:0]   scan_idx [NREQ];
    logic [NREQ-1:0]  done_onehot;
    logic [IDW-1:0]   win_idx;
    logic             win_found;
    logic             to_hit;

    // scan_idx[k] is the requester examined k+1 places after the last winner
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lanes
        assign msg_arr[gi]     = msg_in[gi*MSG_W +: MSG_W];
        assign scan_idx[gi]    = IDW'((int'(rr_ptr_q) + gi + 1) % NREQ);
        assign done_onehot[gi] = (grant_id_q == IDW'(gi));
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req[scan_idx[k]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[k];
            end
        end
    end

`ifdef HARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TO_CYC + 1);

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             err_q, err_d;

    // to_cnt_q holds the number of BUSY cycles already completed
    assign to_hit = (to_cnt_q == CNT_W'(TO_CYC - 1));

    always_comb begin
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        if (state_q == S_ISSUE) begin
            to_cnt_d = '0;
        end else if (state_q == S_BUSY) begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (!core_done && to_hit) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        core_msg_d   = core_msg_q;
        core_start_d = core_start_q;
        digest_d     = digest_q;
        done_d       = '0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    core_msg_d = msg_arr[win_idx];
                    grant_id_d = win_idx;
                    rr_ptr_d   = win_idx;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_start_d = 1'b1;
                state_d      = S_BUSY;
            end
            S_BUSY: begin
                if (core_done) begin
                    digest_d     = core_digest;
                    done_d       = done_onehot;
                    core_start_d = 1'b0;
                    state_d      = S_DRAIN;
                end else if (to_hit) begin
                    done_d       = done_onehot;
                    core_start_d = 1'b0;
                    state_d      = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // a stale end flag must clear before the next job may start
                if (!core_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= IDW'(NREQ - 1);
            grant_id_q   <= '0;
            core_msg_q   <= '0;
            core_start_q <= 1'b0;
            digest_q     <= '0;
            done_q       <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            core_msg_q   <= core_msg_d;
            core_start_q <= core_start_d;
            digest_q     <= digest_d;
            done_q       <= done_d;
        end
    end

    assign done       = done_q;
    assign digest     = digest_q;
    assign grant_id   = grant_id_q;
    assign busy       = (state_q != S_IDLE);
    assign core_msg   = core_msg_q;
    assign core_start = core_start_q;

endmodule

// File: tb/tb_hash_core_arbiter.sv
// Bench for hash_core_arbiter: table of single jobs, directed corner sequences and a randomized
// run, all checked against a transaction-level round-robin model and a behavioural core model.
module tb_hash_core_arbiter;

    localparam int NREQ   = 4;
    localparam int MSG_W  = 512;
    localparam int DIG_W  = 256;
    localparam int TO_CYC = 15;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*MSG_W-1:0] msg_in = '0;
    logic [NREQ-1:0]       done;
    logic [DIG_W-1:0]      digest;
    logic [1:0]            grant_id;
    logic                  busy;
    logic [MSG_W-1:0]      core_msg;
    logic                  core_start;
    logic [DIG_W-1:0]      core_digest = '0;
    logic                  core_done = 1'b0;
    logic                  err;

    hash_core_arbiter #(
        .NREQ(NREQ), .MSG_W(MSG_W), .DIG_W(DIG_W), .TO_CYC(TO_CYC)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .msg_in(msg_in), .done(done),
        .digest(digest), .grant_id(grant_id), .busy(busy), .core_msg(core_msg),
        .core_start(core_start), .core_digest(core_digest), .core_done(core_done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // core model controls
    int lat = 0, hold = 0, cnt = 0, post = 0;
    bit never = 0;
    // reference model state
    int rr_ref = NREQ - 1;
    int exp_win = 0;
    logic [MSG_W-1:0] exp_msg = '0;
    logic [DIG_W-1:0] ref_dig = '0;
    int pulses = 0;
    bit in_job = 0, to_mode = 0, mon_en = 0;
    bit busy_p = 0, start_p = 0, cdone_p = 0;
    int grants[$];
    bit rand_mode = 0;
    int rprob = 0;

    typedef struct {
        logic [NREQ-1:0] req;
        int lat;
        int hold;
        int exp_gnt;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(string name, logic [MSG_W-1:0] act, logic [MSG_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DIG_W-1:0] hfn(logic [MSG_W-1:0] m);
        return m[DIG_W-1:0] ^ m[MSG_W-1 -: DIG_W] ^ {8{32'hA5A5_0F0F}};
    endfunction

    function automatic int pick(logic [NREQ-1:0] r, int last);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [MSG_W-1:0] msg_of(int i);
        return msg_in[i*MSG_W +: MSG_W];
    endfunction

    task automatic set_msg(int i);
        logic [MSG_W-1:0] m;
        for (int w = 0; w < MSG_W / 32; w++) m[w*32 +: 32] = $urandom;
        msg_in[i*MSG_W +: MSG_W] = m;
    endtask

    task automatic tick();
        int w;
        @(negedge clk);
        if (mon_en) begin
            if (busy && !busy_p) begin
                w = pick(req, rr_ref);
                chk("grant_req_present", (w >= 0), 1);
                if (w >= 0) begin
                    exp_win = w;
                    exp_msg = msg_of(w);
                    chk("grant_id", grant_id, w);
                    chk("core_msg", core_msg, exp_msg);
                    rr_ref = w;
                    grants.push_back(w);
                end
                pulses = 0;
                in_job = 1;
            end
            if (core_start && !start_p) chk("start_after_core_done_low", cdone_p, 0);
            if (done != 0) begin
                chk("done_in_job", in_job, 1);
                chk("done_onehot", done, 1 << exp_win);
                if (!to_mode) ref_dig = hfn(exp_msg);
                chk("digest", digest, ref_dig);
                pulses++;
            end else begin
                chk("digest_hold", digest, ref_dig);
            end
            if (!busy && busy_p) begin
                chk("pulses_per_job", pulses, 1);
                in_job = 0;
            end
        end
        // core model: end flag after lat start cycles, held hold cycles after start falls
        if (rand_mode && core_start && !start_p && !core_done) begin
            lat  = $urandom_range(6, 0);
            hold = $urandom_range(3, 0);
        end
        busy_p  = busy;
        start_p = core_start;
        cdone_p = core_done;
        if (reset) begin
            core_done = 1'b0; cnt = 0; post = 0;
        end else if (core_start) begin
            post = 0;
            if (!never && cnt >= lat) begin
                core_done   = 1'b1;
                core_digest = hfn(core_msg);
            end else begin
                cnt++;
            end
        end else begin
            cnt = 0;
            if (core_done) begin
                if (post >= hold) core_done = 1'b0;
                else post++;
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (done[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(99, 0) < rprob) begin
                    set_msg(i);
                    req[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        req    = '0;
        mon_en = 0;
        @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_digest", digest, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_core_msg", core_msg, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        rr_ref = NREQ - 1; ref_dig = '0; in_job = 0;
        busy_p = 0; start_p = 0; cdone_p = 0;
        core_done = 1'b0; cnt = 0; post = 0;
        mon_en = 1;
    endtask

    task automatic wait_idle(string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 300 && !ok; c++) begin
            tick();
            if (!busy && req == 0) ok = 1;
        end
        chk(name, ok, 1);
    endtask

    initial begin
        int dc, sc;
        bit got;
        tbl[0] = '{4'b0001, 10, 0, 0};
        tbl[1] = '{4'b0110,  3, 0, 1};
        tbl[2] = '{4'b0110,  3, 0, 2};
        tbl[3] = '{4'b1001,  2, 0, 3};
        tbl[4] = '{4'b1001,  2, 0, 0};
        tbl[5] = '{4'b1111,  1, 5, 1};
        tbl[6] = '{4'b0100,  0, 2, 2};
        tbl[7] = '{4'b1010,  4, 1, 3};

        do_reset();

        for (int v = 0; v < 8; v++) begin
            lat  = tbl[v].lat;
            hold = tbl[v].hold;
            for (int i = 0; i < NREQ; i++) set_msg(i);
            req = tbl[v].req;
            got = 0;
            for (int c = 0; c < 300 && !got; c++) begin
                tick();
                if (done != 0) got = 1;
            end
            chk("tbl_done_seen", got, 1);
            if (got) begin
                chk("tbl_grant", grant_id, tbl[v].exp_gnt);
                chk("tbl_done", done, 1 << tbl[v].exp_gnt);
                chk("tbl_digest", digest, hfn(msg_of(tbl[v].exp_gnt)));
                req = '0;
                dc = 1;
                for (int c = 0; c < 50; c++) begin
                    tick();
                    if (!busy) break;
                    dc++;
                end
                chk("tbl_drain_cycles", dc, tbl[v].hold + 1);
                chk("tbl_busy_low", busy, 0);
            end
            $display("vector %0d req=%b grant=%0d digest=%0h", v, tbl[v].req, grant_id, digest[31:0]);
        end

        // fairness: all requesters continuously re-raise
        do_reset();
        grants.delete();
        rand_mode = 1;
        rprob = 100;
        for (int c = 0; c < 2000 && grants.size() < 8; c++) tick();
        chk("fair_grant_count", (grants.size() >= 8), 1);
        for (int k = 0; k < 8 && k < grants.size(); k++) begin
            chk("fair_seq", grants[k], k % 4);
            $display("fair grant %0d -> id %0d", k, grants[k]);
        end
        rand_mode = 0;
        req = '0;
        wait_idle("fair_drain");

        // reset during BUSY aborts the job; then requester 3 is served first
        lat = 20; hold = 0;
        set_msg(0);
        req = 4'b0001;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (core_start) got = 1;
        end
        chk("abort_start_seen", got, 1);
        repeat (3) tick();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("abort_no_done", done, 0);
        end
        lat = 3;
        set_msg(3);
        req = 4'b1000;
        got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            tick();
            if (done != 0) got = 1;
        end
        chk("after_abort_done", done, 4'b1000);
        chk("after_abort_grant", grant_id, 3);
        $display("after reset: grant=%0d done=%b", grant_id, done);
        req = '0;
        wait_idle("after_abort_idle");

        // randomized traffic
        rand_mode = 1;
        rprob = 30;
        for (int c = 0; c < 600; c++) tick();
        rand_mode = 0;
        req = '0;
        wait_idle("random_drain");
        $display("random run: %0d grants", grants.size());

        // core that never completes
        do_reset();
        never = 1;
        set_msg(0);
        req = 4'b0001;
`ifdef HARB_TIMEOUT_EN
        to_mode = 1;
        sc = 0;
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            tick();
            if (core_start) sc++;
            if (done != 0) got = 1;
        end
        chk("to_done_seen", got, 1);
        chk("to_busy_cycles", sc, TO_CYC);
        chk("to_err", err, 1);
        req = '0;
        wait_idle("to_drain");
        chk("to_err_sticky", err, 1);
        to_mode = 0;
        $display("timeout: busy cycles=%0d err=%b", sc, err);
`else
        sc = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (done != 0) sc++;
        end
        chk("hang_busy", busy, 1);
        chk("hang_err", err, 0);
        chk("hang_no_done", sc, 0);
        $display("no timeout: busy=%b err=%b", busy, err);
`endif
        never = 0;
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
